// File: rtl/jt6295_mixlp.sv
// rtl/jt6295_mixlp.sv - four-channel ADPCM mixer with 48 kHz resampler and optional IIR low-pass (JT6295_LPF_EN)
module jt6295_mixlp #(
    parameter int LPF_SHIFT = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cen_sr,
    input  logic               cen_sr4,
    input  logic               cen_48k,
    input  logic signed [11:0] ch_snd,
    output logic signed [15:0] mixed,
    output logic               mixed_ok,
    output logic signed [15:0] snd,
    output logic               snd_ok,
    output logic               slot_err
);

    logic signed [13:0] acc_q, acc_d;
    logic        [2:0]  cnt_q, cnt_d;
    logic               armed_q, armed_d;
    logic signed [15:0] mixed_q, mixed_d;
    logic               mixed_ok_q, mixed_ok_d;
    logic               err_q, err_d;
    logic signed [15:0] snd_q, snd_d;
    logic               snd_ok_q, snd_ok_d;
    logic signed [13:0] ch_ext;

    assign ch_ext = {{2{ch_snd[11]}}, ch_snd};

    // Per-period accumulation, latch of the mixed sample and slot-count check
    always_comb begin
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        armed_d    = armed_q;
        mixed_d    = mixed_q;
        mixed_ok_d = 1'b0;
        err_d      = err_q;
        if (cen_sr) begin
            // A slot coinciding with cen_sr opens the new period
            mixed_d    = {acc_q, 2'b00};
            mixed_ok_d = 1'b1;
            armed_d    = 1'b1;
            if (armed_q && cnt_q != 3'd4) begin
                err_d = 1'b1;
            end
            if (cen_sr4) begin
                acc_d = ch_ext;
                cnt_d = 3'd1;
            end else begin
                acc_d = '0;
                cnt_d = 3'd0;
            end
        end else if (cen_sr4) begin
            acc_d = acc_q + ch_ext;
            if (cnt_q != 3'd7) begin
                cnt_d = cnt_q + 3'd1;
            end
        end
    end

`ifdef JT6295_LPF_EN
    // snd_q doubles as the filter state y; the filter reads the pre-update mixed_q
    logic signed [16:0] lpf_diff, lpf_step, lpf_sum;
    logic               lpf_unused;

    always_comb begin
        lpf_diff = {mixed_q[15], mixed_q} - {snd_q[15], snd_q};
        lpf_step = lpf_diff >>> LPF_SHIFT;
        lpf_sum  = {snd_q[15], snd_q} + lpf_step;
        snd_d    = cen_48k ? lpf_sum[15:0] : snd_q;
        snd_ok_d = cen_48k;
    end

    assign lpf_unused = lpf_sum[16];
`else
    logic [2:0] unused_shift;
    assign unused_shift = 3'(LPF_SHIFT);

    // Plain sample-and-hold of the latest mixed sample
    always_comb begin
        snd_d    = cen_48k ? mixed_q : snd_q;
        snd_ok_d = cen_48k;
    end
`endif

    // State registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q      <= '0;
            cnt_q      <= '0;
            armed_q    <= 1'b0;
            mixed_q    <= '0;
            mixed_ok_q <= 1'b0;
            err_q      <= 1'b0;
            snd_q      <= '0;
            snd_ok_q   <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            armed_q    <= armed_d;
            mixed_q    <= mixed_d;
            mixed_ok_q <= mixed_ok_d;
            err_q      <= err_d;
            snd_q      <= snd_d;
            snd_ok_q   <= snd_ok_d;
        end
    end

    assign mixed    = mixed_q;
    assign mixed_ok = mixed_ok_q;
    assign snd      = snd_q;
    assign snd_ok   = snd_ok_q;
    assign slot_err = err_q;

endmodule

// File: tb/tb_jt6295_mixlp.sv
// tb/tb_jt6295_mixlp.sv - directed self-checking bench for jt6295_mixlp
module tb_jt6295_mixlp;

`ifdef JT6295_LPF_EN
    localparam bit LPF = 1'b1;
`else
    localparam bit LPF = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst_n;
    logic               cen_sr, cen_sr4, cen_48k;
    logic signed [11:0] ch_snd;
    logic signed [15:0] mixed, snd;
    logic               mixed_ok, snd_ok, slot_err;

    int n_chk  = 0;
    int n_fail = 0;

    jt6295_mixlp #(.LPF_SHIFT(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cen_sr   (cen_sr),
        .cen_sr4  (cen_sr4),
        .cen_48k  (cen_48k),
        .ch_snd   (ch_snd),
        .mixed    (mixed),
        .mixed_ok (mixed_ok),
        .snd      (snd),
        .snd_ok   (snd_ok),
        .slot_err (slot_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input int exp);
        logic [15:0] e;
        e = 16'(exp);
        n_chk++;
        assert (obs === e) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(e));
        end
    endtask

    task automatic step(input logic sr, input logic sr4, input logic c48, input int ch);
        @(negedge clk);
        cen_sr  = sr;
        cen_sr4 = sr4;
        cen_48k = c48;
        ch_snd  = 12'(ch);
        @(posedge clk);
        #1;
        cen_sr  = 1'b0;
        cen_sr4 = 1'b0;
        cen_48k = 1'b0;
    endtask

    task automatic slot(input int ch);
        step(1'b0, 1'b1, 1'b0, ch);
    endtask

    task automatic period(input int ch);
        step(1'b1, 1'b1, 1'b0, ch);
    endtask

    initial begin
        rst_n = 1'b0; cen_sr = 1'b0; cen_sr4 = 1'b0; cen_48k = 1'b0; ch_snd = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_mixed", mixed, 0);
        check("rst_mixed_ok", {15'd0, mixed_ok}, 0);
        check("rst_snd", snd, 0);
        check("rst_snd_ok", {15'd0, snd_ok}, 0);
        check("rst_slot_err", {15'd0, slot_err}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Partial first period of 2 slots is not checked
        slot(1); slot(2);
        period(100);
        check("first_mixed", mixed, 12);
        check("first_err", {15'd0, slot_err}, 0);

        // 100+200+300+400
        slot(200); slot(300); slot(400);
        period(150);
        check("sum_mixed", mixed, 4000);
        check("sum_ok", {15'd0, mixed_ok}, 1);
        check("sum_err", {15'd0, slot_err}, 0);
        step(1'b0, 1'b0, 1'b0, 0);
        check("sum_ok_drop", {15'd0, mixed_ok}, 0);
        check("sum_hold", mixed, 4000);

        // 48 kHz stage with mixed held at 4000 and y starting from 0
        step(1'b0, 1'b0, 1'b1, 0);
        check("snd1", snd, LPF ? 1000 : 4000);
        check("snd_ok1", {15'd0, snd_ok}, 1);
        step(1'b0, 1'b0, 1'b1, 0);
        check("snd2", snd, LPF ? 1750 : 4000);
        step(1'b0, 1'b0, 1'b1, 0);
        check("snd3", snd, LPF ? 2312 : 4000);
        step(1'b0, 1'b0, 1'b1, 0);
        check("snd4", snd, LPF ? 2734 : 4000);
        step(1'b0, 1'b0, 1'b0, 0);
        check("snd_ok_drop", {15'd0, snd_ok}, 0);
        check("snd_hold", snd, LPF ? 2734 : 4000);

        // Sum 600, then cen_sr coincident with a slot carrying 50
        slot(150); slot(150); slot(150);
        period(50);
        check("coinc_mixed", mixed, 2400);
        check("coinc_err", {15'd0, slot_err}, 0);
        slot(50); slot(50); slot(50);
        // cen_48k coincident with cen_sr filters the old mixed (2400)
        step(1'b1, 1'b1, 1'b1, -2048);
        check("next_mixed", mixed, 800);
        check("coinc48_snd", snd, LPF ? 2650 : 2400);
        check("coinc48_ok", {15'd0, snd_ok}, 1);
        step(1'b0, 1'b0, 1'b1, 0);
        check("after48_snd", snd, LPF ? 2187 : 800);

        // Extremes
        slot(-2048); slot(-2048); slot(-2048);
        period(2047);
        check("min_mixed", mixed, -32768);
        slot(2047); slot(2047); slot(2047);
        period(0);
        check("max_mixed", mixed, 32752);
        check("max_err", {15'd0, slot_err}, 0);

        // Only 3 slots in an armed period, then sticky through good periods
        slot(0); slot(0);
        period(0);
        check("short_err", {15'd0, slot_err}, 1);
        check("short_mixed", mixed, 0);
        slot(3); slot(3); slot(3);
        period(5);
        check("sticky_err", {15'd0, slot_err}, 1);
        check("sticky_mixed", mixed, 36);
        slot(5); slot(5); slot(5);
        step(1'b1, 1'b1, 1'b1, 7);
        check("pre_rst_mixed", mixed, 80);
        check("pre_rst_snd", snd, LPF ? 1649 : 36);

        // Asynchronous reset mid-period with both ok pulses high
        rst_n = 1'b0;
        #1;
        check("mid_rst_mixed", mixed, 0);
        check("mid_rst_mixed_ok", {15'd0, mixed_ok}, 0);
        check("mid_rst_snd", snd, 0);
        check("mid_rst_snd_ok", {15'd0, snd_ok}, 0);
        check("mid_rst_err", {15'd0, slot_err}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // First period after release is unchecked and acc starts from 0
        slot(1);
        period(0);
        check("post_rst_mixed", mixed, 4);
        check("post_rst_err", {15'd0, slot_err}, 0);
        step(1'b0, 1'b0, 1'b1, 0);
        check("post_rst_snd", snd, LPF ? 1 : 4);
        slot(0); slot(0); slot(0);
        step(1'b1, 1'b0, 1'b0, 0);
        check("good_err", {15'd0, slot_err}, 0);
        check("good_mixed", mixed, 0);

        // Back-to-back cen_sr with no slots
        step(1'b1, 1'b0, 1'b0, 0);
        check("b2b_err", {15'd0, slot_err}, 1);
        check("b2b_mixed", mixed, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/jt6295_mixlp.md
# jt6295_mixlp

Output stage fed by the JT6295 timing generator's strobes and the ADPCM channel datapath. Each 4× sample-rate slot delivers one channel's 12-bit decoded sample. The block sums the four channels into a 16-bit mixed sample once per sample period. It then resamples that sample onto the 48 kHz strobe, through a first-order IIR low-pass when compiled in, for the system audio mixer.

## Interface
Clocking: one clock; reset is asynchronous and active-low.

Parameters:
- LPF_SHIFT, 2, IIR coefficient exponent k (α = 2^-k); legal range 1..4.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cen_sr  in  1  sample-rate strobe, one clk wide
- cen_sr4  in  1  channel-slot strobe, four per sample period; the first coincides with cen_sr
- cen_48k  in  1  48 kHz output strobe, one clk wide, asynchronous to cen_sr phase
- ch_snd  in  12  signed channel sample, valid when cen_sr4=1
- mixed  out  16  signed mixed sample (sum of four channels ×4)
- mixed_ok  out  1  one-cycle pulse, mixed just updated
- snd  out  16  signed 48 kHz output sample
- snd_ok  out  1  one-cycle pulse, snd just updated
- slot_err  out  1  sticky: a checked sample period did not contain exactly 4 slots

## Operation
- Accumulator acc, 14-bit signed. On cen_sr4 without cen_sr: acc += sext(ch_snd). The range -8192..8188 cannot overflow, so no saturation logic.
- On cen_sr:
  - mixed ← {acc, 2'b00}.
  - If cen_sr4 is also high: acc ← sext(ch_snd), slot count ← 1.
  - Otherwise: acc ← 0, slot count ← 0.
- Slot counter: 3-bit, saturating at 7, incremented on each cen_sr4 without cen_sr.
- Slot check on cen_sr:
  - If armed and slot count ≠ 4, set slot_err. slot_err clears only on reset.
  - armed is set on the first cen_sr after reset, so the partial first period is never checked.
- 48 kHz stage on cen_48k:
  - With LPF: y ← y + ((mixed − y) >>> LPF_SHIFT). The difference is 17-bit signed and the shift is arithmetic (rounds toward −∞). y stays within the 16-bit range, so there is no clamp. snd ← new y.
  - Without LPF: snd ← mixed (sample-and-hold).
- Strobes are qualifiers only. Registers hold when no strobe is active.

## Timing
- Reset values: acc=0, slot count=0, armed=0, mixed=0, mixed_ok=0, y=0, snd=0, snd_ok=0, slot_err=0. rst_n low clears everything immediately, mid-period included.
- mixed and mixed_ok: both register on the cen_sr clk edge and are visible one cycle later. mixed_ok is high for exactly 1 cycle.
- snd and snd_ok: both register on the cen_sr48k clk edge and are visible one cycle later. snd_ok is high for exactly 1 cycle.
- cen_48k coincident with cen_sr: the filter uses the old mixed. The new sample is picked up at the next cen_48k.
- cen_sr coincident with cen_sr4: the slot belongs to the new period and is excluded from the latched sum.
- Back-to-back cen_sr with no cen_sr4: mixed ← 0. If armed, slot_err is set.
- No backpressure. Consumers must sample on the ok pulses.

## Configuration
- JT6295_LPF_EN defined: the IIR filter and the y register are built, and snd is the filtered value.
- JT6295_LPF_EN undefined: the y register and filter arithmetic are removed, and snd is a sample-and-hold of mixed at cen_48k. The LPF_SHIFT parameter is ignored.
- Port list and strobe timing are identical in both builds.

## Test plan
- Four slots with ch_snd = 100, 200, 300, 400, then cen_sr:
  - mixed = 4000 and mixed_ok = 1 for one cycle, starting the cycle after cen_sr.
  - slot_err = 0 once armed.
- Extremes:
  - All four slots at −2048 → mixed = −32768.
  - All four slots at 2047 → mixed = 32752.
- LPF_SHIFT=2 with JT6295_LPF_EN defined, mixed held at 4000 from reset:
  - Successive cen_48k give snd = 1000, 1750, 2312, 2734.
  - With the macro undefined, the first cen_48k gives snd = 4000.
- cen_sr coincident with a cen_sr4 carrying ch_snd = 50, previous sum 600:
  - mixed = 2400.
  - The next period's sum includes 50.
- Slot counting:
  - After arming, only 3 cen_sr4 between two cen_sr → slot_err = 1, staying set through later correct periods.
  - A 2-slot first period after reset → slot_err stays 0.
- rst_n pulsed low mid-period with acc ≠ 0 and snd ≠ 0 → mixed, snd, slot_err and the ok pulses all read 0 during reset, and the first period after release is unchecked.
